// File: rtl/pe_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : pe_stim_gen
// Description : Parametrised stimulus source for the PE array. Emits ifmap,
//               filter and psum words on a valid/ready stream, stamped with
//               X/Y bus tags. Word issue is throttled by an internal PE-rate
//               strobe that emulates the slow PE clock on the fast clock.
//               Data modes: LFSR random, increment, constant.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rstn            : clock, asynchronous active-low reset
//   start / stop         : begin a burst (IDLE only) / abort the burst
//   mode                 : 0 random, 1/3 increment, 2 constant
//   burst_len            : words per burst, 0 = unbounded (latched on start)
//   const_val            : word for constant mode (latched on start)
//   x_tag_i / y_tag_i    : bus tags to stamp (latched on start)
//   data_ready           : sink accepts the current word
//   pe_en                : one-cycle strobe every PE_DIV clocks
//   data_valid           : data outputs hold a valid word
//   ifmap/fltr/psum_data : generated words
//   x_tag_o / y_tag_o    : latched tags
//   busy / done          : burst running / bounded burst completed (pulse)
//   word_cnt             : words transferred in the current burst
// ============================================================================
module pe_stim_gen #(
  parameter int          DATA_WIDTH = 16,
  parameter int          NUM_COL    = 4,
  parameter int          NUM_ROW    = 4,
  parameter int          PE_DIV     = 4,
  parameter logic [31:0] SEED_A     = 32'hACE1_1234,
  parameter logic [31:0] SEED_B     = 32'h5EED_0F0F
) (
  input  logic                                              clk,
  input  logic                                              rstn,
  input  logic                                              start,
  input  logic                                              stop,
  input  logic [1:0]                                        mode,
  input  logic [15:0]                                       burst_len,
  input  logic [DATA_WIDTH-1:0]                             const_val,
  input  logic [((NUM_COL > 1) ? $clog2(NUM_COL) : 1)-1:0]  x_tag_i,
  input  logic [((NUM_ROW > 1) ? $clog2(NUM_ROW) : 1)-1:0]  y_tag_i,
  input  logic                                              data_ready,
  output logic                                              pe_en,
  output logic                                              data_valid,
  output logic [DATA_WIDTH-1:0]                             ifmap_data,
  output logic [DATA_WIDTH-1:0]                             fltr_data,
  output logic [2*DATA_WIDTH-1:0]                           psum_data,
  output logic [((NUM_COL > 1) ? $clog2(NUM_COL) : 1)-1:0]  x_tag_o,
  output logic [((NUM_ROW > 1) ? $clog2(NUM_ROW) : 1)-1:0]  y_tag_o,
  output logic                                              busy,
  output logic                                              done,
  output logic [15:0]                                       word_cnt
);

  // --------------------------------------------------------------------------
  // Local parameters
  // --------------------------------------------------------------------------
  localparam int XW     = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
  localparam int YW     = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
  localparam int PSUM_W = 2 * DATA_WIDTH;
  localparam int DIV_W  = (PE_DIV > 1) ? $clog2(PE_DIV) : 1;

  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(PE_DIV - 1);
  localparam logic [31:0]           LFSR_MASK = 32'h8020_0003;
  localparam logic [DATA_WIDTH-1:0] ONE_D     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PSUM_W-1:0]     ONE_P     = {{(PSUM_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]           CNT_MAX   = 16'hFFFF;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // --------------------------------------------------------------------------
  // Galois LFSR step, x^32+x^22+x^2+x+1, right shifting
  // --------------------------------------------------------------------------
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'd0);
  endfunction

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic [DIV_W-1:0]      div_cnt;
  logic [31:0]           lfsr_a;
  logic [31:0]           lfsr_b;

  logic [1:0]            mode_q;
  logic [15:0]           len_q;
  logic [DATA_WIDTH-1:0] const_q;

  logic                  go;
  logic                  xfer;
  logic                  abort;
  logic                  gen;
  logic                  last;
  logic                  done_nxt;
  logic [15:0]           cnt_inc;
  logic [16:0]           k_plus1;

  logic [DATA_WIDTH-1:0] gen_ifmap;
  logic [DATA_WIDTH-1:0] gen_fltr;
  logic [PSUM_W-1:0]     gen_psum;
  logic [DATA_WIDTH-1:0] rnd_ifmap;
  logic [DATA_WIDTH-1:0] rnd_fltr;
  logic [PSUM_W-1:0]     rnd_psum;

  // --------------------------------------------------------------------------
  // PE-rate divider: free running from reset, independent of the FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign pe_en = (div_cnt == DIV_LAST);

  // --------------------------------------------------------------------------
  // Control terms
  // --------------------------------------------------------------------------
  assign go    = (state == ST_IDLE) && start && !stop;
  assign xfer  = data_valid && data_ready;
  assign abort = (state == ST_RUN) && stop;
  // New words are only produced while the output slot is empty; a stop in
  // the same cycle suppresses generation so the LFSRs do not advance.
  assign gen   = (state == ST_RUN) && pe_en && !data_valid && !stop;

  assign cnt_inc  = (word_cnt == CNT_MAX) ? CNT_MAX : (word_cnt + 16'd1);
  assign last     = xfer && (len_q != 16'd0) && (cnt_inc == len_q);
  // An abort never reports completion, even if the final word slips through
  // on the same edge.
  assign done_nxt = (state == ST_RUN) && last && !stop;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop || last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    case (state)
      ST_RUN:  busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Word generation
  // --------------------------------------------------------------------------
  // Word index k equals the number of words already transferred, because a
  // new word is generated only after the previous one has left.
  assign k_plus1 = {1'b0, word_cnt} + 17'd1;

  // Random fields take the current LFSR state; zero fields become 1 so the
  // sink never sees a degenerate operand.
  assign rnd_ifmap = (lfsr_a[DATA_WIDTH-1:0] == '0) ? ONE_D : lfsr_a[DATA_WIDTH-1:0];
  assign rnd_fltr  = (lfsr_b[DATA_WIDTH-1:0] == '0) ? ONE_D : lfsr_b[DATA_WIDTH-1:0];

  always_comb begin
    rnd_psum = {lfsr_b[31 -: DATA_WIDTH], lfsr_a[31 -: DATA_WIDTH]};
    if (rnd_psum == '0) begin
      rnd_psum = ONE_P;
    end
  end

  always_comb begin
    gen_ifmap = '0;
    gen_fltr  = '0;
    gen_psum  = '0;
    case (mode_q)
      2'd0: begin
        gen_ifmap = rnd_ifmap;
        gen_fltr  = rnd_fltr;
        gen_psum  = rnd_psum;
      end
      2'd2: begin
        gen_ifmap = const_q;
        gen_fltr  = const_q;
        gen_psum  = {{DATA_WIDTH{1'b0}}, const_q};
      end
      default: begin
        gen_ifmap = DATA_WIDTH'(k_plus1);
        gen_fltr  = DATA_WIDTH'(k_plus1);
        gen_psum  = PSUM_W'(k_plus1);
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Burst configuration, latched only on start
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q  <= 2'd0;
      len_q   <= 16'd0;
      const_q <= '0;
      x_tag_o <= '0;
      y_tag_o <= '0;
    end else if (go) begin
      mode_q  <= mode;
      len_q   <= burst_len;
      const_q <= const_val;
      x_tag_o <= x_tag_i;
      y_tag_o <= y_tag_i;
    end
  end

  // --------------------------------------------------------------------------
  // Stream outputs, word counter and done pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_valid <= 1'b0;
      ifmap_data <= '0;
      fltr_data  <= '0;
      psum_data  <= '0;
      word_cnt   <= 16'd0;
      done       <= 1'b0;
    end else begin
      done <= done_nxt;

      if (go) begin
        word_cnt <= 16'd0;
      end else if (xfer) begin
        word_cnt <= cnt_inc;
      end

      if (xfer || abort) begin
        data_valid <= 1'b0;
      end else if (gen) begin
        data_valid <= 1'b1;
        ifmap_data <= gen_ifmap;
        fltr_data  <= gen_fltr;
        psum_data  <= gen_psum;
      end
    end
  end

  // --------------------------------------------------------------------------
  // LFSRs: advance once per random word, persist across bursts
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr_a <= SEED_A;
      lfsr_b <= SEED_B;
    end else if (gen && (mode_q == 2'd0)) begin
      lfsr_a <= lfsr_next(lfsr_a);
      lfsr_b <= lfsr_next(lfsr_b);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_stim_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_stim_gen
// Description : Directed self-checking bench for pe_stim_gen with default
//               parameters (DATA_WIDTH=16, PE_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_stim_gen;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [15:0] burst_len;
  logic [15:0] const_val;
  logic [1:0]  x_tag_i;
  logic [1:0]  y_tag_i;
  logic        data_ready;
  logic        pe_en;
  logic        data_valid;
  logic [15:0] ifmap_data;
  logic [15:0] fltr_data;
  logic [31:0] psum_data;
  logic [1:0]  x_tag_o;
  logic [1:0]  y_tag_o;
  logic        busy;
  logic        done;
  logic [15:0] word_cnt;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [31:0] a_m;
  logic [31:0] b_m;
  logic [15:0] e_if;
  logic [15:0] e_fl;
  logic [31:0] e_ps;

  pe_stim_gen #(
    .DATA_WIDTH (16),
    .NUM_COL    (4),
    .NUM_ROW    (4),
    .PE_DIV     (4),
    .SEED_A     (32'hACE1_1234),
    .SEED_B     (32'h5EED_0F0F)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .burst_len  (burst_len),
    .const_val  (const_val),
    .x_tag_i    (x_tag_i),
    .y_tag_i    (y_tag_i),
    .data_ready (data_ready),
    .pe_en      (pe_en),
    .data_valid (data_valid),
    .ifmap_data (ifmap_data),
    .fltr_data  (fltr_data),
    .psum_data  (psum_data),
    .x_tag_o    (x_tag_o),
    .y_tag_o    (y_tag_o),
    .busy       (busy),
    .done       (done),
    .word_cnt   (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for the next valid word
  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!data_valid && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, data_valid}, 32'd1);
  endtask

  // Golden Galois step
  function automatic logic [31:0] g_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  task automatic model_word();
    e_if = (a_m[15:0] == 16'd0) ? 16'd1 : a_m[15:0];
    e_fl = (b_m[15:0] == 16'd0) ? 16'd1 : b_m[15:0];
    e_ps = {b_m[31:16], a_m[31:16]};
    if (e_ps == 32'd0) e_ps = 32'd1;
    a_m = g_step(a_m);
    b_m = g_step(b_m);
  endtask

  initial begin
    rstn       = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    mode       = 2'd0;
    burst_len  = 16'd0;
    const_val  = 16'd0;
    x_tag_i    = 2'd0;
    y_tag_i    = 2'd0;
    data_ready = 1'b0;
    a_m        = 32'hACE1_1234;
    b_m        = 32'h5EED_0F0F;

    // ---------------- reset state ----------------
    tick(1);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_pe_en", {31'd0, pe_en}, 32'd0);
    chk("rst_cnt",   {16'd0, word_cnt}, 32'd0);
    chk("rst_ifmap", {16'd0, ifmap_data}, 32'd0);
    chk("rst_psum",  psum_data, 32'd0);
    tick(1);
    rstn = 1'b1;

    // ---------------- divider, idle ----------------
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("pe_en_c%0d", i), {31'd0, pe_en}, ((i % 4) == 3) ? 32'd1 : 32'd0);
      chk("idle_valid", {31'd0, data_valid}, 32'd0);
      tick(1);
    end

    // ---------------- increment burst (cycle 12) ----------------
    start = 1'b1; mode = 2'd1; burst_len = 16'd3; data_ready = 1'b1;
    x_tag_i = 2'd2; y_tag_i = 2'd1;
    tick(1);                                             // 13
    start = 1'b0;
    chk("inc_busy",  {31'd0, busy}, 32'd1);
    chk("inc_cnt0",  {16'd0, word_cnt}, 32'd0);
    chk("inc_xtag",  {30'd0, x_tag_o}, 32'd2);
    chk("inc_ytag",  {30'd0, y_tag_o}, 32'd1);
    tick(2);                                             // 15
    chk("inc_pre_valid", {31'd0, data_valid}, 32'd0);
    tick(1);                                             // 16
    chk("inc_v1",    {31'd0, data_valid}, 32'd1);
    chk("inc_if1",   {16'd0, ifmap_data}, 32'd1);
    chk("inc_fl1",   {16'd0, fltr_data}, 32'd1);
    chk("inc_ps1",   psum_data, 32'd1);
    tick(1);                                             // 17
    chk("inc_drop1", {31'd0, data_valid}, 32'd0);
    chk("inc_cnt1",  {16'd0, word_cnt}, 32'd1);
    tick(3);                                             // 20
    chk("inc_v2",    {31'd0, data_valid}, 32'd1);
    chk("inc_if2",   {16'd0, ifmap_data}, 32'd2);
    tick(1);                                             // 21
    chk("inc_cnt2",  {16'd0, word_cnt}, 32'd2);
    chk("inc_nodone",{31'd0, done}, 32'd0);
    tick(3);                                             // 24
    chk("inc_v3",    {31'd0, data_valid}, 32'd1);
    chk("inc_fl3",   {16'd0, fltr_data}, 32'd3);
    chk("inc_ps3",   psum_data, 32'd3);
    tick(1);                                             // 25
    chk("inc_done",  {31'd0, done}, 32'd1);
    chk("inc_cnt3",  {16'd0, word_cnt}, 32'd3);
    chk("inc_idle",  {31'd0, busy}, 32'd0);
    chk("inc_v_off", {31'd0, data_valid}, 32'd0);
    tick(1);                                             // 26
    chk("inc_done_pulse", {31'd0, done}, 32'd0);
    chk("inc_cnt_hold",   {16'd0, word_cnt}, 32'd3);

    // ---------------- backpressure, constant mode ----------------
    start = 1'b1; mode = 2'd2; const_val = 16'h00A5; burst_len = 16'd0;
    data_ready = 1'b0;
    tick(1);                                             // 27
    start = 1'b0;
    mode = 2'd1; const_val = 16'h1234;                   // must be ignored
    chk("bp_busy", {31'd0, busy}, 32'd1);
    tick(1);                                             // 28
    for (int j = 0; j < 10; j++) begin
      chk("bp_valid", {31'd0, data_valid}, 32'd1);
      chk("bp_ifmap", {16'd0, ifmap_data}, 32'h0000_00A5);
      chk("bp_psum",  psum_data, 32'h0000_00A5);
      tick(1);
    end                                                  // 38
    chk("bp_cnt0", {16'd0, word_cnt}, 32'd0);
    data_ready = 1'b1;
    tick(1);                                             // 39
    chk("bp_cnt1",  {16'd0, word_cnt}, 32'd1);
    chk("bp_drop",  {31'd0, data_valid}, 32'd0);
    data_ready = 1'b0;
    tick(1);                                             // 40
    chk("bp_v2",      {31'd0, data_valid}, 32'd1);
    chk("bp_cnt_one", {16'd0, word_cnt}, 32'd1);
    chk("bp_if2",     {16'd0, ifmap_data}, 32'h0000_00A5);
    stop = 1'b1;
    tick(1);                                             // 41
    stop = 1'b0;
    chk("bp_stop_v",    {31'd0, data_valid}, 32'd0);
    chk("bp_stop_busy", {31'd0, busy}, 32'd0);
    chk("bp_stop_done", {31'd0, done}, 32'd0);

    // ---------------- random burst ----------------
    start = 1'b1; mode = 2'd0; burst_len = 16'd5; data_ready = 1'b1;
    tick(1);
    start = 1'b0;
    for (int w = 0; w < 5; w++) begin
      wait_valid("rnd_wait");
      model_word();
      chk("rnd_ifmap", {16'd0, ifmap_data}, {16'd0, e_if});
      chk("rnd_fltr",  {16'd0, fltr_data}, {16'd0, e_fl});
      chk("rnd_psum",  psum_data, e_ps);
      chk("rnd_nz", {31'd0, (ifmap_data != 16'd0) && (fltr_data != 16'd0) && (psum_data != 32'd0)}, 32'd1);
      if (w == 0) begin
        chk("rnd_w0_if", {16'd0, ifmap_data}, 32'h0000_1234);
        chk("rnd_w0_fl", {16'd0, fltr_data}, 32'h0000_0F0F);
        chk("rnd_w0_ps", psum_data, 32'h5EED_ACE1);
      end
      if (w == 1) begin
        chk("rnd_w1_if", {16'd0, ifmap_data}, 32'h0000_891A);
        chk("rnd_w1_fl", {16'd0, fltr_data}, 32'h0000_8784);
        chk("rnd_w1_ps", psum_data, 32'hAF56_5670);
      end
      tick(1);
    end
    chk("rnd_done", {31'd0, done}, 32'd1);
    chk("rnd_cnt",  {16'd0, word_cnt}, 32'd5);

    // second burst continues the sequence
    tick(1);
    start = 1'b1; burst_len = 16'd2;
    tick(1);
    start = 1'b0;
    for (int w = 0; w < 2; w++) begin
      wait_valid("rnd2_wait");
      model_word();
      chk("rnd2_ifmap", {16'd0, ifmap_data}, {16'd0, e_if});
      chk("rnd2_fltr",  {16'd0, fltr_data}, {16'd0, e_fl});
      chk("rnd2_psum",  psum_data, e_ps);
      tick(1);
    end
    chk("rnd2_done", {31'd0, done}, 32'd1);
    chk("rnd2_cnt",  {16'd0, word_cnt}, 32'd2);

    // ---------------- abort, unbounded ----------------
    tick(1);
    start = 1'b1; mode = 2'd1; burst_len = 16'd0; data_ready = 1'b1;
    tick(1);
    start = 1'b0;
    wait_valid("ab_wait1");
    tick(1);
    wait_valid("ab_wait2");
    tick(1);
    data_ready = 1'b0;
    chk("ab_cnt2",   {16'd0, word_cnt}, 32'd2);
    chk("ab_nodone", {31'd0, done}, 32'd0);
    wait_valid("ab_wait3");
    chk("ab_if3", {16'd0, ifmap_data}, 32'd3);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("ab_valid", {31'd0, data_valid}, 32'd0);
    chk("ab_busy",  {31'd0, busy}, 32'd0);
    chk("ab_done",  {31'd0, done}, 32'd0);
    chk("ab_cnt",   {16'd0, word_cnt}, 32'd2);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick(1);
    chk("ss_busy1", {31'd0, busy}, 32'd0);
    tick(1);
    chk("ss_busy2",  {31'd0, busy}, 32'd0);
    chk("ss_valid",  {31'd0, data_valid}, 32'd0);
    start = 1'b0; stop = 1'b0;

    // ---------------- reset mid-burst ----------------
    start = 1'b1; mode = 2'd0; burst_len = 16'd0; data_ready = 1'b0;
    x_tag_i = 2'd3; y_tag_i = 2'd2;
    tick(1);
    start = 1'b0;
    wait_valid("mr_wait");
    chk("mr_xtag", {30'd0, x_tag_o}, 32'd3);
    #2 rstn = 1'b0;
    #1;
    chk("mr_valid", {31'd0, data_valid}, 32'd0);
    chk("mr_ifmap", {16'd0, ifmap_data}, 32'd0);
    chk("mr_fltr",  {16'd0, fltr_data}, 32'd0);
    chk("mr_psum",  psum_data, 32'd0);
    chk("mr_xtag0", {30'd0, x_tag_o}, 32'd0);
    chk("mr_ytag0", {30'd0, y_tag_o}, 32'd0);
    chk("mr_busy",  {31'd0, busy}, 32'd0);
    chk("mr_cnt",   {16'd0, word_cnt}, 32'd0);
    chk("mr_pe_en", {31'd0, pe_en}, 32'd0);
    tick(1);
    rstn = 1'b1;
    start = 1'b1; mode = 2'd0; burst_len = 16'd1; data_ready = 1'b1;
    tick(1);
    start = 1'b0;
    wait_valid("mr2_wait");
    chk("mr2_if", {16'd0, ifmap_data}, 32'h0000_1234);
    chk("mr2_fl", {16'd0, fltr_data}, 32'h0000_0F0F);
    chk("mr2_ps", psum_data, 32'h5EED_ACE1);
    tick(1);
    chk("mr2_done", {31'd0, done}, 32'd1);
    chk("mr2_cnt",  {16'd0, word_cnt}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
